read_flash_control: RTL and testbench

//  Read-side counterpart of the page writer: fetches up to PAGES_PER_REQ logged pages from NAND into page RAM.

---
 rtl/read_flash_control.sv | 197 +++++++++++++++++++
 tb/tb_read_flash_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_flash_control.sv
// Read-side page fetcher: pulls up to PAGES_PER_REQ logged pages from NAND into page RAM slots.
// Optional build macro READ_RETRY_EN re-reads a failed page up to MAX_RETRY times before dropping it.
module read_flash_control #(
    parameter int unsigned PAGES_PER_REQ  = 3,
    parameter int unsigned DATA_STATE     = 10,
    parameter int unsigned LAST_DATA_PAGE = 126,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_read,
    output logic        end_read,
    output logic [2:0]  pages_read,
    output logic        read_empty,
    output logic        read_err,
    output logic        en_read_page,
    input  logic        end_read_page,
    input  logic [4:0]  state,
    input  logic [13:0] read_data_cnt,
    input  logic [7:0]  read_data,
    input  logic [1:0]  read_addr_row_error,
    input  logic [1:0]  read_success,
    output logic [23:0] read_addr_row,
    input  logic [23:0] end_addr_row,
    input  logic [23:0] init_addr_row,
    input  logic        en_init_flash_addr,
    output logic        end_init_flash_addr,
    output logic        read_en_ram,
    output logic [14:0] read_ram_addr,
    output logic [7:0]  read_ram_datain,
    output logic        en_readAddr_Transfer,
    input  logic        end_readAddr_Transfer
);

    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned RETRY_W = 3;

    if (PAGES_PER_REQ < 1 || PAGES_PER_REQ > 4 || MAX_RETRY > 7) begin : g_param_check
        $error("read_flash_control: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_EVAL, S_DONE} fsm_t;

    fsm_t              cur_st, nxt_st;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_inc;
    logic [1:0]        rowerr_q, rowerr_d, succ_q, succ_d;
    logic [23:0]       row_d, row_adv, row_nblk;
    logic [2:0]        pages_read_d;
    logic              end_read_d, empty_d, err_d, en_page_d, end_init_d, xfer_d;
    logic              at_end, is_bad, is_fail;
`ifdef READ_RETRY_EN
    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    // Page RAM write port: spare-area bytes (cnt[13]) never reach RAM
    assign read_en_ram     = (state == 5'(DATA_STATE)) & ~read_data_cnt[13];
    assign read_ram_addr   = {slot_q[1:0], read_data_cnt[13] ? 13'd0 : read_data_cnt[12:0]};
    assign read_ram_datain = read_data;

    assign slot_inc = slot_q + SLOT_W'(1);
    assign at_end   = (read_addr_row == end_addr_row);
    assign is_bad   = (rowerr_q == 2'd2);
    assign is_fail  = (succ_q == 2'd2);
    assign row_nblk = {read_addr_row[23:19], read_addr_row[18:7] + 12'd1, 7'd0};
    assign row_adv  = (read_addr_row[6:0] == 7'(LAST_DATA_PAGE)) ? row_nblk
                    : {read_addr_row[23:19], read_addr_row[18:0] + 19'd1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st               <= S_IDLE;
            slot_q               <= '0;
            rowerr_q             <= '0;
            succ_q               <= '0;
            read_addr_row        <= '0;
            pages_read           <= '0;
            end_read             <= 1'b0;
            read_empty           <= 1'b0;
            read_err             <= 1'b0;
            en_read_page         <= 1'b0;
            end_init_flash_addr  <= 1'b0;
            en_readAddr_Transfer <= 1'b0;
`ifdef READ_RETRY_EN
            retry_q              <= '0;
`endif
        end else begin
            cur_st               <= nxt_st;
            slot_q               <= slot_d;
            rowerr_q             <= rowerr_d;
            succ_q               <= succ_d;
            read_addr_row        <= row_d;
            pages_read           <= pages_read_d;
            end_read             <= end_read_d;
            read_empty           <= empty_d;
            read_err             <= err_d;
            en_read_page         <= en_page_d;
            end_init_flash_addr  <= end_init_d;
            en_readAddr_Transfer <= xfer_d;
`ifdef READ_RETRY_EN
            retry_q              <= retry_d;
`endif
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_IDLE:  if (en_read && !en_init_flash_addr) nxt_st = S_CHECK;
            S_CHECK: nxt_st = at_end ? S_DONE : S_ISSUE;
            S_ISSUE: nxt_st = S_WAIT;
            S_WAIT:  if (end_read_page) nxt_st = S_EVAL;
            S_EVAL: begin
                if (is_bad) begin
                    nxt_st = S_CHECK;
                end else if (is_fail) begin
`ifdef READ_RETRY_EN
                    nxt_st = (retry_q < RETRY_W'(MAX_RETRY)) ? S_ISSUE : S_CHECK;
`else
                    nxt_st = S_CHECK;
`endif
                end else begin
                    nxt_st = (slot_inc == SLOT_W'(PAGES_PER_REQ)) ? S_DONE : S_CHECK;
                end
            end
            S_DONE:  nxt_st = S_IDLE;
            default: nxt_st = S_IDLE;
        endcase
    end

    always_comb begin
        slot_d       = slot_q;
        rowerr_d     = rowerr_q;
        succ_d       = succ_q;
        row_d        = read_addr_row;
        pages_read_d = pages_read;
        end_read_d   = 1'b0;
        empty_d      = read_empty;
        err_d        = read_err;
        en_page_d    = en_read_page;
`ifdef READ_RETRY_EN
        retry_d      = retry_q;
`endif
        // Init ack follows the request level, but only a request seen in IDLE raises it
        end_init_d   = en_init_flash_addr ? ((cur_st == S_IDLE) | end_init_flash_addr) : 1'b0;
        // Transfer ack wins over a coinciding DONE
        xfer_d       = end_readAddr_Transfer ? 1'b0 : ((cur_st == S_DONE) | en_readAddr_Transfer);
        case (cur_st)
            S_IDLE: begin
                if (en_init_flash_addr) begin
                    row_d   = init_addr_row;
                    empty_d = 1'b0;
                    err_d   = 1'b0;
                end else if (en_read) begin
                    slot_d = '0;
                end
            end
            S_CHECK: if (at_end) empty_d = 1'b1;
            S_ISSUE: en_page_d = 1'b1;
            S_WAIT: begin
                if (end_read_page) begin
                    en_page_d = 1'b0;
                    rowerr_d  = read_addr_row_error;
                    succ_d    = read_success;
                end
            end
            S_EVAL: begin
                if (is_bad) begin
                    row_d = row_nblk;
                end else if (is_fail) begin
`ifdef READ_RETRY_EN
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        row_d   = row_adv;
                    end
`else
                    err_d = 1'b1;
                    row_d = row_adv;
`endif
                end else begin
                    slot_d = slot_inc;
                    row_d  = row_adv;
`ifdef READ_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            S_DONE: begin
                end_read_d   = 1'b1;
                pages_read_d = slot_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_read_flash_control.sv
// Directed bench for read_flash_control with a behavioural page-read engine.
module tb_read_flash_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_read = 1'b0;
    logic        end_read;
    logic [2:0]  pages_read;
    logic        read_empty, read_err, en_read_page;
    logic        end_read_page = 1'b0;
    logic [4:0]  state = 5'd0;
    logic [13:0] read_data_cnt = 14'd0;
    logic [7:0]  read_data = 8'd0;
    logic [1:0]  rowerr = 2'd0, succ = 2'd0;
    logic [23:0] read_addr_row;
    logic [23:0] end_addr_row = 24'hFFFFFF;
    logic [23:0] init_addr_row = 24'd0;
    logic        en_init = 1'b0, end_init;
    logic        read_en_ram;
    logic [14:0] read_ram_addr;
    logic [7:0]  read_ram_datain;
    logic        xfer, end_xfer = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [23:0] req_q[$];
    logic [14:0] ram_addr_q[$];
    logic        ram_en_q[$];
    logic        spare_en_q[$];
    logic [23:0] bad_row = 24'hFFFFFF;
    logic [23:0] fail_row = 24'hFFFFFF;
    int          fail_left = 0;
    bit          eng_off = 1'b0;

    read_flash_control dut (
        .clk(clk), .rst(rst), .en_read(en_read), .end_read(end_read), .pages_read(pages_read),
        .read_empty(read_empty), .read_err(read_err), .en_read_page(en_read_page),
        .end_read_page(end_read_page), .state(state), .read_data_cnt(read_data_cnt),
        .read_data(read_data), .read_addr_row_error(rowerr), .read_success(succ),
        .read_addr_row(read_addr_row), .end_addr_row(end_addr_row), .init_addr_row(init_addr_row),
        .en_init_flash_addr(en_init), .end_init_flash_addr(end_init), .read_en_ram(read_en_ram),
        .read_ram_addr(read_ram_addr), .read_ram_datain(read_ram_datain),
        .en_readAddr_Transfer(xfer), .end_readAddr_Transfer(end_xfer)
    );

    always #5 clk = ~clk;

    // Page-read engine: one data byte, one spare byte, then a status pulse
    initial begin : engine
        forever begin
            @(negedge clk);
            if (!eng_off && en_read_page === 1'b1) begin
                req_q.push_back(read_addr_row);
                state = 5'd10; read_data_cnt = 14'd0; read_data = 8'h5A;
                #1;
                ram_addr_q.push_back(read_ram_addr);
                ram_en_q.push_back(read_en_ram);
                @(negedge clk);
                read_data_cnt = 14'h2000;
                #1;
                spare_en_q.push_back(read_en_ram);
                @(negedge clk);
                state = 5'd0; read_data_cnt = 14'd0;
                if (read_addr_row == bad_row) begin
                    rowerr = 2'd2; succ = 2'd0;
                end else if (read_addr_row == fail_row && fail_left > 0) begin
                    rowerr = 2'd1; succ = 2'd2; fail_left--;
                end else begin
                    rowerr = 2'd1; succ = 2'd1;
                end
                end_read_page = 1'b1;
                @(negedge clk);
                end_read_page = 1'b0; rowerr = 2'd0; succ = 2'd0;
            end
        end
    end

    task automatic clear_q();
        req_q.delete(); ram_addr_q.delete(); ram_en_q.delete(); spare_en_q.delete();
    endtask

    task automatic do_init(input logic [23:0] row);
        @(negedge clk);
        init_addr_row = row; en_init = 1'b1;
        @(negedge clk);
        en_init = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_batch(output logic [2:0] pages, output bit tmo);
        int n = 0;
        en_read = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!end_read && n < 500);
        tmo = !end_read;
        pages = pages_read;
        en_read = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({end_read, pages_read, read_empty, read_err, en_read_page, read_addr_row, end_init, xfer} !== '0)
            begin errors++; $display("FAIL reset_outputs got row=%h page=%b end=%b init=%b xfer=%b want all 0",
                read_addr_row, en_read_page, end_read, end_init, xfer); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_init();
        @(negedge clk);
        init_addr_row = 24'h000010; en_init = 1'b1; en_read = 1'b1;
        @(negedge clk);
        checks++;
        if (end_init !== 1'b1 || read_addr_row !== 24'h000010) begin errors++;
            $display("FAIL init_ack got ack=%b row=%h want 1 000010", end_init, read_addr_row); end
        @(negedge clk);
        checks++;
        if (end_init !== 1'b1) begin errors++; $display("FAIL init_hold got %b want 1", end_init); end
        en_init = 1'b0; en_read = 1'b0;
        @(negedge clk);
        checks++;
        if (end_init !== 1'b0) begin errors++; $display("FAIL init_release got %b want 0", end_init); end
        repeat (3) @(negedge clk);
        checks++;
        if (en_read_page !== 1'b0 || req_q.size() != 0) begin errors++;
            $display("FAIL init_priority got page=%b reqs=%0d want 0 0", en_read_page, req_q.size()); end
    endtask

    task automatic test_basic_batch();
        logic [2:0] pg; bit tmo;
        clear_q();
        run_batch(pg, tmo);
        checks++;
        if (tmo || pg !== 3'd3) begin errors++; $display("FAIL basic_pages got %0d tmo=%b want 3", pg, tmo); end
        checks++;
        if (req_q.size() != 3 || req_q[0] !== 24'h10 || req_q[1] !== 24'h11 || req_q[2] !== 24'h12) begin
            errors++; $display("FAIL basic_rows got %p want 10 11 12", req_q); end
        checks++;
        if (ram_addr_q.size() != 3 || ram_addr_q[0] !== 15'h0000 || ram_addr_q[1] !== 15'h2000
            || ram_addr_q[2] !== 15'h4000) begin
            errors++; $display("FAIL basic_ram_addr got %p want 0000 2000 4000", ram_addr_q); end
        checks++;
        if (ram_en_q.size() != 3 || ram_en_q[0] !== 1'b1 || spare_en_q.size() != 3 || spare_en_q[0] !== 1'b0)
            begin errors++; $display("FAIL basic_ram_en got data=%p spare=%p want 1s and 0s", ram_en_q, spare_en_q); end
        checks++;
        if (xfer !== 1'b1 || read_addr_row !== 24'h13) begin errors++;
            $display("FAIL basic_after got xfer=%b row=%h want 1 000013", xfer, read_addr_row); end
        @(negedge clk);
        checks++;
        if (end_read !== 1'b0) begin errors++; $display("FAIL end_read_width got %b want 0", end_read); end
        read_data = 8'hC3; #1;
        checks++;
        if (read_ram_datain !== 8'hC3) begin errors++; $display("FAIL ram_datain got %h want c3", read_ram_datain); end
        end_xfer = 1'b1;
        @(negedge clk);
        end_xfer = 1'b0;
        checks++;
        if (xfer !== 1'b0) begin errors++; $display("FAIL xfer_ack got %b want 0", xfer); end
    endtask

    task automatic test_info_page_skip();
        logic [2:0] pg; bit tmo;
        do_init(24'h00007D);
        clear_q();
        run_batch(pg, tmo);
        checks++;
        if (tmo || pg !== 3'd3 || req_q.size() != 3 || req_q[0] !== 24'h7D || req_q[1] !== 24'h7E
            || req_q[2] !== 24'h80) begin
            errors++; $display("FAIL info_skip got pages=%0d rows=%p want 3 7d 7e 80", pg, req_q); end
        checks++;
        if (read_addr_row !== 24'h81) begin errors++; $display("FAIL info_skip_row got %h want 000081", read_addr_row); end
    endtask

    task automatic test_bad_block();
        logic [2:0] pg; bit tmo;
        do_init(24'h000100);
        clear_q();
        bad_row = 24'h000100;
        run_batch(pg, tmo);
        bad_row = 24'hFFFFFF;
        checks++;
        if (tmo || pg !== 3'd3 || req_q.size() != 4 || req_q[0] !== 24'h100 || req_q[1] !== 24'h180
            || req_q[3] !== 24'h182) begin
            errors++; $display("FAIL bad_block got pages=%0d rows=%p want 3 100 180 181 182", pg, req_q); end
        checks++;
        if (ram_addr_q.size() < 2 || ram_addr_q[1] !== 15'h0000) begin errors++;
            $display("FAIL bad_block_slot got %p want second entry 0000", ram_addr_q); end
    endtask

    task automatic test_empty();
        logic [2:0] pg; bit tmo;
        do_init(24'h000010);
        end_addr_row = 24'h000012;
        clear_q();
        run_batch(pg, tmo);
        checks++;
        if (tmo || pg !== 3'd2 || read_empty !== 1'b1 || req_q.size() != 2) begin errors++;
            $display("FAIL empty_partial got pages=%0d empty=%b reqs=%0d want 2 1 2", pg, read_empty, req_q.size()); end
        @(negedge clk);
        clear_q();
        run_batch(pg, tmo);
        checks++;
        if (tmo || pg !== 3'd0 || req_q.size() != 0) begin errors++;
            $display("FAIL empty_again got pages=%0d reqs=%0d want 0 0", pg, req_q.size()); end
        end_addr_row = 24'hFFFFFF;
        do_init(24'h000200);
        checks++;
        if (read_empty !== 1'b0) begin errors++; $display("FAIL empty_clear got %b want 0", read_empty); end
    endtask

    task automatic test_fail();
        logic [2:0] pg; bit tmo;
        logic [23:0] exp1;
        int exp_n;
`ifdef READ_RETRY_EN
        exp1 = 24'h200; exp_n = 6;
`else
        exp1 = 24'h201; exp_n = 4;
`endif
        clear_q();
        fail_row = 24'h000200; fail_left = 3;
        run_batch(pg, tmo);
        fail_row = 24'hFFFFFF; fail_left = 0;
        checks++;
        if (tmo || pg !== 3'd3 || read_err !== 1'b1) begin errors++;
            $display("FAIL fail_batch got pages=%0d err=%b want 3 1", pg, read_err); end
        checks++;
        if (req_q.size() != exp_n || req_q[1] !== exp1 || read_addr_row !== 24'h204) begin errors++;
            $display("FAIL fail_rows got %p row=%h want %0d reqs, second %h, end 204", req_q, read_addr_row, exp_n, exp1); end
        do_init(24'h000300);
        checks++;
        if (read_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", read_err); end
    endtask

    task automatic test_reset_mid_page();
        int n = 0;
        bit seen = 1'b0;
        eng_off = 1'b1;
        en_read = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!en_read_page && n < 50);
        en_read = 1'b0;
        checks++;
        if (en_read_page !== 1'b1) begin errors++; $display("FAIL midpage_issue got %b want 1", en_read_page); end
        rst = 1'b1;
        #1;
        checks++;
        if (en_read_page !== 1'b0) begin errors++; $display("FAIL midpage_async got %b want 0", en_read_page); end
        @(negedge clk);
        rst = 1'b0;
        end_read_page = 1'b1; rowerr = 2'd1; succ = 2'd1;
        @(negedge clk);
        end_read_page = 1'b0; rowerr = 2'd0; succ = 2'd0;
        repeat (10) begin
            @(negedge clk);
            if (end_read || en_read_page) seen = 1'b1;
        end
        checks++;
        if (seen || read_addr_row !== 24'd0) begin errors++;
            $display("FAIL midpage_ignore got activity=%b row=%h want 0 000000", seen, read_addr_row); end
        eng_off = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int pulses = 0;
        do_init(24'h000400);
        clear_q();
        en_read = 1'b1;
        while (pulses < 2 && n < 400) begin
            @(negedge clk);
            n++;
            if (end_read) pulses++;
        end
        en_read = 1'b0;
        checks++;
        if (pulses != 2 || req_q.size() != 6 || req_q[3] !== 24'h403 || req_q[5] !== 24'h405) begin errors++;
            $display("FAIL back_to_back got pulses=%0d rows=%p want 2 400..405", pulses, req_q); end
        repeat (3) @(negedge clk);
        checks++;
        if (en_read_page !== 1'b0) begin errors++; $display("FAIL b2b_stop got %b want 0", en_read_page); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_basic_batch();
        test_info_page_skip();
        test_bad_block();
        test_empty();
        test_fail();
        test_reset_mid_page();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
